// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts rising edges of an asynchronous sig_in over a
// fixed window of GATE_CYCLES clk cycles and reports count, range and overflow.
module clk_freq_meter #(
  parameter int unsigned GATE_CYCLES = 50000,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned EXP_MIN     = 0,
  parameter int unsigned EXP_MAX     = (1 << CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             sig_in,
  output logic             busy,
  output logic [CNT_W-1:0] meas_cnt,
  output logic             meas_valid,
  output logic             in_range,
  output logic             overflow
);

  localparam int unsigned GW = 24;
  localparam int unsigned XW = CNT_W + 1;
  localparam logic [GW-1:0] GATE_LOAD = GW'(GATE_CYCLES - 1);
  localparam logic [XW-1:0] MIN_X     = XW'(EXP_MIN);
  localparam logic [XW-1:0] MAX_X     = XW'(EXP_MAX);

  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  state_t           state_q;
  logic             sync1_q, sync2_q, hist_q;
  logic [GW-1:0]    gate_q;
  logic [CNT_W-1:0] edge_q;
  logic             ovf_q;
  logic             busy_q, meas_valid_q, in_range_q, overflow_q;
  logic [CNT_W-1:0] meas_cnt_q;

  logic             edge_c;
  logic [CNT_W-1:0] edge_d;
  logic             ovf_d;
  logic             in_range_d;
  logic [XW-1:0]    diff_lo, diff_hi;

  assign edge_c = sync2_q & ~hist_q;

  // Saturating edge count including this cycle's pulse; range test via sign of differences
  always_comb begin
    edge_d = edge_q;
    ovf_d  = ovf_q;
    if (edge_c) begin
      if (edge_q == {CNT_W{1'b1}}) begin
        ovf_d = 1'b1;
      end else begin
        edge_d = edge_q + CNT_W'(1);
      end
    end
    diff_lo    = {1'b0, edge_d} - MIN_X;
    diff_hi    = MAX_X - {1'b0, edge_d};
    in_range_d = ~diff_lo[XW-1] & ~diff_hi[XW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      gate_q       <= '0;
      edge_q       <= '0;
      ovf_q        <= 1'b0;
      busy_q       <= 1'b0;
      meas_cnt_q   <= '0;
      meas_valid_q <= 1'b0;
      in_range_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= sig_in;
      sync2_q      <= sync1_q;
      hist_q       <= sync2_q;
      meas_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= GATE;
            gate_q  <= GATE_LOAD;
            edge_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        GATE: begin
          edge_q <= edge_d;
          ovf_q  <= ovf_d;
          gate_q <= gate_q - GW'(1);
          // Last window cycle: publish results so they are visible during DONE
          if (gate_q == '0) begin
            state_q      <= DONE;
            meas_cnt_q   <= edge_d;
            overflow_q   <= ovf_d;
            in_range_q   <= in_range_d;
            meas_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (cont) begin
            state_q <= GATE;
            gate_q  <= GATE_LOAD;
            edge_q  <= '0;
            ovf_q   <= 1'b0;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign meas_cnt   = meas_cnt_q;
  assign meas_valid = meas_valid_q;
  assign in_range   = in_range_q;
  assign overflow   = overflow_q;

endmodule
